// File: rtl/cordic_rot.sv
// Iterative rotation-mode CORDIC: 32-bit phase (2^32 per turn) in, Q2.30 cosine/sine out.
// One micro-rotation per clock, valid/ready handshake on both sides.
module cordic_rot #(
    parameter int ITER = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] phase,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] cos_out,
    output logic [31:0] sin_out
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [31:0] K    = 32'h26DD3B6A;
    localparam logic [4:0]  LAST = 5'(ITER - 1);

    // round(atan(2^-i) / (2*pi) * 2^32)
    localparam logic [31:0] ATAN [32] = '{
        32'h20000000, 32'h12E4051E, 32'h09FB385B, 32'h051111D4,
        32'h028B0D43, 32'h0145D7E1, 32'h00A2F61E, 32'h00517C55,
        32'h0028BE53, 32'h00145F2F, 32'h000A2F98, 32'h000517CC,
        32'h00028BE6, 32'h000145F3, 32'h0000A2FA, 32'h0000517D,
        32'h000028BE, 32'h0000145F, 32'h00000A30, 32'h00000518,
        32'h0000028C, 32'h00000146, 32'h000000A3, 32'h00000051,
        32'h00000029, 32'h00000014, 32'h0000000A, 32'h00000005,
        32'h00000003, 32'h00000001, 32'h00000001, 32'h00000000
    };

    state_t             state, state_nx;
    logic [4:0]         cnt;
    logic signed [31:0] x, y, z;
    logic signed [31:0] xs, ys, atan_i;
    logic signed [31:0] x_nx, y_nx, z_nx;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid)    state_nx = RUN;
            RUN:     if (cnt == LAST) state_nx = DONE;
            DONE:    if (out_ready)   state_nx = IDLE;
            default:                  state_nx = IDLE;
        endcase
    end

    always_comb begin
        xs     = x >>> cnt;
        ys     = y >>> cnt;
        atan_i = ATAN[cnt];
        if (!z[31]) begin
            x_nx = x - ys;
            y_nx = y + xs;
            z_nx = z - atan_i;
        end else begin
            x_nx = x + ys;
            y_nx = y - xs;
            z_nx = z + atan_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            x       <= '0;
            y       <= '0;
            z       <= '0;
            cos_out <= '0;
            sin_out <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    cnt <= '0;
                    // Quadrant pre-rotation leaves |z| < 90 degrees
                    case (phase[31:30])
                        2'b00: begin x <= K;  y <= '0; z <= phase;                end
                        2'b01: begin x <= '0; y <= K;  z <= phase - 32'h40000000; end
                        2'b10: begin x <= -K; y <= '0; z <= phase - 32'h80000000; end
                        default: begin x <= K; y <= '0; z <= phase;               end
                    endcase
                end
                RUN: begin
                    x   <= x_nx;
                    y   <= y_nx;
                    z   <= z_nx;
                    cnt <= cnt + 5'd1;
                    if (cnt == LAST) begin
                        cos_out <= x_nx;
                        sin_out <= y_nx;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_rot.sv
// Bench for cordic_rot: directed quadrant/diagonal/backpressure/reset cases plus a
// random phase sweep compared against real-valued cos/sin.
module tb_cordic_rot;

    localparam int  ITER = 24;
    localparam real PI   = 3.14159265358979323846;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] phase;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] cos_out;
    logic [31:0] sin_out;

    int checks = 0;
    int errors = 0;

    cordic_rot #(.ITER(ITER)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .phase    (phase),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .cos_out  (cos_out),
        .sin_out  (sin_out)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic longint ideal(input logic [31:0] ph, input bit want_sin);
        real a, v;
        a = 2.0 * PI * real'(longint'(ph)) / 4294967296.0;
        v = want_sin ? $sin(a) : $cos(a);
        return longint'($floor(v * 1073741824.0 + 0.5));
    endfunction

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_near(input string tag, input logic [31:0] obs, input longint exp);
        longint d;
        checks++;
        d = longint'($signed(obs)) - exp;
        if (d < 0) d = -d;
        assert ((d <= 64'sd512) === 1'b1) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d (+-512)", tag, longint'($signed(obs)), exp);
        end
    endtask

    // One full transaction: accept, wait for result, stall, handshake, compare to model
    task automatic run_one(input logic [31:0] ph, input int stall, input bit noise);
        int          lat;
        logic [31:0] c0, s0;
        lat = 0;
        while (!in_ready && lat < 50) begin
            tick();
            lat++;
        end
        check("in_ready_before_accept", longint'(in_ready), 1);
        in_valid  = 1'b1;
        phase     = ph;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            if (noise) begin
                in_valid = 1'($urandom);
                phase    = $urandom;
            end
            tick();
            lat++;
        end
        check("latency", lat, ITER);
        c0 = cos_out;
        s0 = sin_out;
        check_near("cos", c0, ideal(ph, 1'b0));
        check_near("sin", s0, ideal(ph, 1'b1));
        for (int k = 0; k < stall; k++) begin
            if (noise) begin
                in_valid = 1'($urandom);
                phase    = $urandom;
            end
            tick();
            check("hold_cos", longint'(cos_out), longint'(c0));
            check("hold_sin", longint'(sin_out), longint'(s0));
            check("hold_in_ready", longint'(in_ready), 0);
            check("hold_out_valid", longint'(out_valid), 1);
        end
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("post_hs_out_valid", longint'(out_valid), 0);
        check("post_hs_in_ready", longint'(in_ready), 1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        phase     = '0;
        out_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        check("rst_in_ready", longint'(in_ready), 1);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_cos", longint'(cos_out), 0);
        check("rst_sin", longint'(sin_out), 0);

        run_one(32'h00000000, 0, 1'b0);
        run_one(32'h40000000, 1, 1'b0);
        run_one(32'h80000000, 0, 1'b0);
        run_one(32'hC0000000, 2, 1'b0);
        run_one(32'h20000000, 0, 1'b0);
        run_one(32'hE0000000, 0, 1'b0);
        check_near("diag_const", 32'h2D413CCD, ideal(32'h20000000, 1'b0));

        // Backpressure: ten stalled cycles in DONE
        run_one(32'h15555555, 10, 1'b0);

        // Reset during RUN discards the run
        in_valid = 1'b1;
        phase    = 32'h12345678;
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_cos", longint'(cos_out), 0);
        check("midrst_sin", longint'(sin_out), 0);
        check("midrst_out_valid", longint'(out_valid), 0);
        check("midrst_in_ready", longint'(in_ready), 1);
        tick();
        check("midrst_stays_idle", longint'(out_valid), 0);
        run_one(32'h40000000, 0, 1'b0);

        for (int n = 0; n < 1000; n++) begin
            run_one($urandom, int'($urandom_range(0, 3)), 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
